// File: rtl/lfsr_stream_decryptor.sv
// Streaming LFSR decryptor: seeds from the first ciphertext byte, keeps the tap pattern whose
// keystream decodes the preamble to PAD, strips leading pad and emits a fixed-length plaintext run.
module lfsr_stream_decryptor #(
    parameter int D_W      = 8,
    parameter int LFSR_W   = 7,
    parameter int NUM_PTRN = 9,
    parameter logic [NUM_PTRN*LFSR_W-1:0] PTRN_LIST =
        {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60},
    parameter logic [D_W-1:0] PAD = 8'h20,
    parameter int DET_LEN  = 10,
    parameter int IN_LEN   = 64,
    parameter int OUT_LEN  = 64
) (
    input  logic                        clk,
    input  logic                        init,
    input  logic                        req,
    output logic                        ack,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [D_W-1:0]              in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [D_W-1:0]              out_data,
    output logic [$clog2(NUM_PTRN)-1:0] ptrn_idx,
    output logic                        ptrn_err,
    output logic [$clog2(IN_LEN+1)-1:0] perr_cnt
);
    localparam int P_W    = D_W - 1;
    localparam int IDX_W  = $clog2(NUM_PTRN);
    localparam int ICNT_W = $clog2(IN_LEN + 1);
    localparam int OCNT_W = $clog2(OUT_LEN + 1);

    typedef enum logic [2:0] {IDLE, DETECT, DECRYPT, FLUSH, DONE} state_t;
    state_t state_reg, state_next;

    logic [NUM_PTRN-1:0][LFSR_W-1:0] cand_reg, cand_next, cand_step, ptrn_tab;
    logic [NUM_PTRN-1:0]             alive_reg, alive_next, alive_upd;
    logic [LFSR_W-1:0]               work_reg, work_next, work_step;
    logic                            strip_reg, strip_next;
    logic [ICNT_W-1:0]               in_cnt_reg, in_cnt_next;
    logic [OCNT_W-1:0]               out_cnt_reg, out_cnt_next;
    logic [D_W-1:0]                  out_data_reg, out_data_next;
    logic                            out_valid_reg, out_valid_next;
    logic [IDX_W-1:0]                ptrn_idx_reg, ptrn_idx_next, low_idx;
    logic                            ptrn_err_reg, ptrn_err_next;
    logic [ICNT_W-1:0]               perr_cnt_reg, perr_cnt_next;

    logic           perr, in_fire, out_free;
    logic [P_W-1:0] plain;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] p);
        return {s[LFSR_W-2:0], ^(s & p)};
    endfunction

    assign perr     = ^in_data;
    assign out_free = ~out_valid_reg | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign ack      = (state_reg == DONE);

    // One candidate keystream per tap pattern; a candidate survives while every
    // clean preamble byte it decrypts comes out as PAD.
    for (genvar gi = 0; gi < NUM_PTRN; gi++) begin : g_cand
        assign ptrn_tab[gi]  = PTRN_LIST[gi*LFSR_W +: LFSR_W];
        assign cand_step[gi] = lfsr_step(cand_reg[gi], ptrn_tab[gi]);
        assign alive_upd[gi] = alive_reg[gi] &
            (perr | ((in_data[P_W-1:0] ^ P_W'(cand_step[gi])) == PAD[P_W-1:0]));
    end

    assign work_step = lfsr_step(work_reg, ptrn_tab[ptrn_idx_reg]);
    assign plain     = in_data[P_W-1:0] ^ P_W'(work_step);

    always_comb begin
        low_idx = '0;
        for (int k = NUM_PTRN - 1; k >= 0; k--) begin
            if (alive_upd[k]) low_idx = IDX_W'(k);
        end
    end

    always_comb begin
        case (state_reg)
            DETECT:  in_ready = 1'b1;
            DECRYPT: in_ready = out_free;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        alive_next     = alive_reg;
        work_next      = work_reg;
        strip_next     = strip_reg;
        in_cnt_next    = in_cnt_reg;
        out_cnt_next   = out_cnt_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg & ~out_ready;
        ptrn_idx_next  = ptrn_idx_reg;
        ptrn_err_next  = ptrn_err_reg;
        perr_cnt_next  = perr_cnt_reg;

        if (in_fire) begin
            in_cnt_next = in_cnt_reg + 1'b1;
            if (perr && perr_cnt_reg != ICNT_W'(IN_LEN)) perr_cnt_next = perr_cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (req) begin
                    ptrn_err_next = 1'b0;
                    perr_cnt_next = '0;
                    in_cnt_next   = '0;
                    out_cnt_next  = '0;
                    state_next    = DETECT;
                end
            end
            DETECT: begin
                if (in_fire) begin
                    if (in_cnt_reg == '0) begin
                        if (perr) begin
                            ptrn_err_next = 1'b1;
                            state_next    = DONE;
                        end else begin
                            for (int k = 0; k < NUM_PTRN; k++)
                                cand_next[k] = in_data[LFSR_W-1:0] ^ PAD[LFSR_W-1:0];
                            alive_next = '1;
                        end
                    end else begin
                        cand_next  = cand_step;
                        alive_next = alive_upd;
                        if (alive_upd == '0) begin
                            ptrn_err_next = 1'b1;
                            state_next    = DONE;
                        end else if (in_cnt_reg == ICNT_W'(DET_LEN - 1)) begin
                            ptrn_idx_next = low_idx;
                            work_next     = cand_step[low_idx];
                            strip_next    = 1'b1;
                            state_next    = DECRYPT;
                        end
                    end
                end
            end
            DECRYPT: begin
                if (in_fire) begin
                    work_next = work_step;
                    // Leading clean pad bytes are swallowed; anything else ends stripping.
                    if (!(strip_reg && !perr && plain == PAD[P_W-1:0])) begin
                        strip_next = 1'b0;
                        if (out_cnt_reg != OCNT_W'(OUT_LEN)) begin
                            out_data_next  = {perr, plain};
                            out_valid_next = 1'b1;
                            out_cnt_next   = out_cnt_reg + 1'b1;
                        end
                    end
                    if (in_cnt_reg == ICNT_W'(IN_LEN - 1)) state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Leave only once the final byte has actually been handed downstream.
                if (out_cnt_reg == OCNT_W'(OUT_LEN)) begin
                    if (out_free) state_next = DONE;
                end else if (out_free) begin
                    out_data_next  = {1'b0, PAD[P_W-1:0]};
                    out_valid_next = 1'b1;
                    out_cnt_next   = out_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (!req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state_reg     <= IDLE;
            cand_reg      <= '0;
            alive_reg     <= '0;
            work_reg      <= '0;
            strip_reg     <= 1'b0;
            in_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            ptrn_idx_reg  <= '0;
            ptrn_err_reg  <= 1'b0;
            perr_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            alive_reg     <= alive_next;
            work_reg      <= work_next;
            strip_reg     <= strip_next;
            in_cnt_reg    <= in_cnt_next;
            out_cnt_reg   <= out_cnt_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            ptrn_idx_reg  <= ptrn_idx_next;
            ptrn_err_reg  <= ptrn_err_next;
            perr_cnt_reg  <= perr_cnt_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign ptrn_idx  = ptrn_idx_reg;
    assign ptrn_err  = ptrn_err_reg;
    assign perr_cnt  = perr_cnt_reg;

endmodule

// File: tb/tb_lfsr_stream_decryptor.sv
// Bench for lfsr_stream_decryptor: encrypts known text with a reference LFSR and checks the
// decrypted stream through a scoreboard queue, plus status outputs after every run.
module tb_lfsr_stream_decryptor;
    localparam logic [62:0] PTRNS =
        {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60};

    logic       clk = 1'b0;
    logic       init, req, in_valid, out_ready;
    logic [7:0] in_data;
    logic       ack, in_ready, out_valid, ptrn_err;
    logic [7:0] out_data;
    logic [3:0] ptrn_idx;
    logic [6:0] perr_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  cipher  [64];
    logic [7:0]  exp_arr [64];
    logic [7:0]  exp_q [$];
    logic [62:0] ptrns;
    string       msg = "four score and seven years ago our fathers brought forth";

    lfsr_stream_decryptor dut (
        .clk(clk), .init(init), .req(req), .ack(ack),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ptrn_idx(ptrn_idx), .ptrn_err(ptrn_err), .perr_cnt(perr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] lfsr(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    // A seed is ambiguous when a lower-index pattern yields the same window keystream.
    function automatic bit ambiguous(input logic [6:0] seed, input int k, input logic [62:0] pl);
        for (int j = 0; j < k; j++) begin
            logic [6:0] a;
            logic [6:0] b;
            bit same;
            a = seed; b = seed; same = 1'b1;
            for (int t = 0; t < 9; t++) begin
                a = lfsr(a, pl[k*7 +: 7]);
                b = lfsr(b, pl[j*7 +: 7]);
                if (a != b) same = 1'b0;
            end
            if (same) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_stream(input logic [6:0] p, input logic [6:0] seed, input int pre,
                                input int cidx, input logic [7:0] cmask);
        logic [6:0] s, pl, c7;
        logic [7:0] ch;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            if (i < pre || i - pre >= msg.len()) begin
                pl = 7'h20;
            end else begin
                ch = msg[i - pre];
                pl = ch[6:0];
            end
            c7 = pl ^ s;
            cipher[i]  = {^c7, c7};
            exp_arr[i] = {1'b0, pl};
            s = lfsr(s, p);
        end
        if (cmask != 8'h00) begin
            cipher[cidx]  = cipher[cidx] ^ cmask;
            exp_arr[cidx] = {1'b1, exp_arr[cidx][6:0] ^ cmask[6:0]};
        end
        exp_q.delete();
    endtask

    task automatic run_stream(input string name, input int pre, input bit bp, input int rst_at,
                              input int exp_idx, input logic exp_err, input int exp_perr,
                              input int exp_outs, input int exp_in);
        int idx, nout, cyc;
        logic [7:0] e;
        idx = 0; nout = 0; cyc = 0;
        @(negedge clk);
        req = 1'b1;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (ack) break;
            out_ready = bp ? (cyc % 4 == 1 || cyc % 4 == 0) : 1'b1;
            in_valid  = (idx < 64) && (!bp || $urandom_range(0, 1) == 1);
            if (idx < 64) in_data = cipher[idx];
            else          in_data = 8'h00;
            #1;
            if (out_valid && out_ready) begin
                check({name, ".out_expected"}, exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("%s.out[%0d]", name, nout), out_data, e);
                end
                nout++;
                if (nout == rst_at) begin
                    init = 1'b0;
                    #1;
                    check({name, ".rst_out_valid"}, out_valid, 0);
                    check({name, ".rst_in_ready"},  in_ready, 0);
                    check({name, ".rst_ack"},       ack, 0);
                    check({name, ".rst_ptrn_idx"},  ptrn_idx, 0);
                    check({name, ".rst_ptrn_err"},  ptrn_err, 0);
                    check({name, ".rst_perr_cnt"},  perr_cnt, 0);
                    in_valid = 1'b0; req = 1'b0; out_ready = 1'b1;
                    @(negedge clk);
                    init = 1'b1;
                    exp_q.delete();
                    $display("run %s: reset after %0d outputs, %0d inputs", name, nout, idx);
                    return;
                end
            end
            if (in_valid && in_ready) begin
                if (idx >= pre) exp_q.push_back(exp_arr[idx]);
                idx++;
                if (idx == 64) for (int j = 0; j < pre; j++) exp_q.push_back(8'h20);
            end
        end
        check({name, ".ack"},          ack, 1);
        check({name, ".in_ready_done"}, in_ready, 0);
        if (exp_idx >= 0) check({name, ".ptrn_idx"}, ptrn_idx, exp_idx);
        check({name, ".ptrn_err"},     ptrn_err, exp_err);
        check({name, ".perr_cnt"},     perr_cnt, exp_perr);
        check({name, ".num_outputs"},  nout, exp_outs);
        check({name, ".num_inputs"},   idx, exp_in);
        check({name, ".queue_empty"},  exp_q.size(), 0);
        req = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check({name, ".ack_drop"}, ack, 0);
        $display("run %s: ptrn_idx=%0d ptrn_err=%0d perr_cnt=%0d outputs=%0d inputs=%0d cycles=%0d",
                 name, ptrn_idx, ptrn_err, perr_cnt, nout, idx, cyc);
    endtask

    initial begin
        logic [6:0] seed;
        init = 1'b0; req = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        ptrns = PTRNS;
        #12;
        check("reset.ack",       ack, 0);
        check("reset.in_ready",  in_ready, 0);
        check("reset.out_valid", out_valid, 0);
        check("reset.ptrn_err",  ptrn_err, 0);
        check("reset.ptrn_idx",  ptrn_idx, 0);
        check("reset.perr_cnt",  perr_cnt, 0);
        @(negedge clk);
        init = 1'b1;

        build_stream(7'h72, 7'h55, 10, 0, 8'h00);
        run_stream("clean", 10, 1'b0, -1, 3, 1'b0, 0, 64, 64);

        build_stream(7'h60, 7'h01, 10, 0, 8'h00);
        run_stream("trivial_seed", 10, 1'b0, -1, 0, 1'b0, 0, 64, 64);

        build_stream(7'h72, 7'h55, 10, 30, 8'h04);
        run_stream("corrupt_byte30", 10, 1'b0, -1, 3, 1'b0, 1, 64, 64);

        build_stream(7'h72, 7'h55, 10, 0, 8'h80);
        run_stream("corrupt_byte0", 10, 1'b0, -1, -1, 1'b1, 1, 0, 1);

        build_stream(7'h72, 7'h55, 10, 0, 8'h00);
        run_stream("backpressure", 10, 1'b1, -1, 3, 1'b0, 0, 64, 64);

        build_stream(7'h72, 7'h55, 10, 0, 8'h00);
        run_stream("reset_mid", 10, 1'b0, 20, 3, 1'b0, 0, 64, 64);
        build_stream(7'h72, 7'h55, 10, 0, 8'h00);
        run_stream("after_reset", 10, 1'b0, -1, 3, 1'b0, 0, 64, 64);

        for (int k = 0; k < 9; k++) begin
            seed = 7'($urandom_range(1, 127));
            for (int t = 0; t < 200 && ambiguous(seed, k, ptrns); t++)
                seed = 7'($urandom_range(1, 127));
            build_stream(ptrns[k*7 +: 7], seed, 26, 0, 8'h00);
            run_stream($sformatf("sweep%0d_seed%02h", k, seed), 26, 1'b0, -1, k, 1'b0, 0, 64, 64);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_stream_decryptor.md
Name: lfsr_stream_decryptor

Overview:
Streaming, parametrised decryption engine for LFSR-encrypted messages that carry a parity bit in the MSB.
- Reads ciphertext bytes and seeds the LFSR from the first byte, using the known pad character.
- Identifies the tap pattern automatically from the padded preamble.
- Strips leading pad characters and flags parity-corrupted characters.
- Emits a fixed-length plaintext stream, then raises ack.

It sits between the data-memory reader and writer in the top level, replacing the software decrypt program with a hardware engine.

Parameters:
D_W, 8, character width; bit D_W-1 is parity, bits D_W-2:0 are payload.
LFSR_W, 7, LFSR state width; must be <= D_W-1.
NUM_PTRN, 9, number of candidate tap patterns.
PTRN_LIST, {7B,7E,5C,69,6A,72,78,48,60} (hex), NUM_PTRN*LFSR_W packed; index 0 in the LSBs.
PAD, 8'h20, preamble and post-fill character.
DET_LEN, 10, detection-window length in bytes; the preamble is guaranteed to be >= DET_LEN.
IN_LEN, 64, ciphertext bytes consumed per run.
OUT_LEN, 64, plaintext bytes emitted per run.

Ports:
clk  in  1  clock, rising edge
init  in  1  reset, asynchronous, active-low
req  in  1  start request
ack  out  1  run complete
in_valid  in  1  ciphertext byte valid
in_ready  out  1  engine accepts ciphertext byte
in_data  in  D_W  ciphertext byte
out_valid  out  1  plaintext byte valid
out_ready  in  1  downstream accepts plaintext byte
out_data  out  D_W  {perr, plaintext[D_W-2:0]}
ptrn_idx  out  $clog2(NUM_PTRN)  detected pattern index
ptrn_err  out  1  no pattern matched / byte 0 corrupt
perr_cnt  out  $clog2(IN_LEN+1)  parity errors seen this run

Behaviour:
- Reset (init low, asynchronous): state=IDLE; ack, in_ready, out_valid, ptrn_err = 0; ptrn_idx, perr_cnt, all counters and LFSR states = 0. Reset mid-run aborts the run immediately; no partial flush.
- Handshakes: a transfer occurs when valid&ready on a rising edge.
  - out_data/out_valid are registered; they hold stable while out_valid & !out_ready.
  - in_ready never depends combinationally on in_valid.
- Parity check: perr = ^in_data (even parity over all D_W bits fails).
  - Each accepted byte with perr increments perr_cnt, which saturates at IN_LEN.
- LFSR step: next = {s[LFSR_W-2:0], ^(s & P)}.
- Decrypt: plain[D_W-2:0] = in_data[D_W-2:0] ^ zero-extend(s).
- States:
  - IDLE: in_ready=0. When req=1, clear ptrn_err and perr_cnt, then go to DETECT.
  - DETECT: in_ready=1, no output.
    - Byte 0 perr: set ptrn_err and go to DONE. No further input is consumed.
    - Byte 0 otherwise: every candidate state = in_data[LFSR_W-1:0] ^ PAD[LFSR_W-1:0]; alive mask = all ones.
    - Bytes 1..DET_LEN-1: advance every candidate. Clear alive[k] if the byte decrypted with candidate k's state differs from PAD. Bytes with perr advance but do not eliminate.
    - After byte DET_LEN-1: ptrn_idx = lowest alive index, and that candidate's state becomes the working state; go to DECRYPT.
    - If alive mask = 0: set ptrn_err and go to DONE.
    - Window bytes are never emitted.
  - DECRYPT: in_ready = out_ready | !out_valid; the state advances once per accepted byte.
    - strip flag starts at 1. While strip=1, a byte with !perr and plain==PAD is consumed without output.
    - The first byte with perr, or with plain!=PAD, clears strip.
    - Emitted bytes are {perr, plain}.
    - When IN_LEN bytes have been accepted in total, go to FLUSH.
    - If OUT_LEN bytes have already been emitted, extra input is still consumed but dropped.
  - FLUSH: emit {1'b0, PAD[D_W-2:0]} until OUT_LEN bytes total, then go to DONE.
  - DONE: ack=1, in_ready=0. Go to IDLE when req=0; ack drops the same cycle IDLE is entered.
- Simultaneous in-accept and out-accept in DECRYPT sustains 1 byte/cycle.
- Latency: an accepted byte appears on out_data in the next cycle.
- req is ignored outside IDLE and DONE.

Test Plan:
- Clean run: ptrn 0x72 (idx 3), seed 0x55, preamble 10 spaces, then "four score and seven years ago..." -> ptrn_idx=3, ptrn_err=0, first out 0x66, 64 outputs, trailing outputs 0x20, perr_cnt=0, ack=1.
- Trivial seed: ptrn 0x60, seed 0x01; byte0=0x21, byte1=0x22, and so on -> LFSR state 0x02 after byte 0, ptrn_idx=0.
- Corruption: same as the clean run, but flip bit 2 of ciphertext byte 30 -> that output has bit7=1, perr_cnt=1, all other outputs match plaintext.
- Byte 0 parity flipped -> ptrn_err=1, zero outputs, in_ready=0 after byte 0, ack=1; req low returns to IDLE.
- Backpressure: out_ready pattern 1,0,0,1 repeating, with in_valid random -> output sequence identical to the clean run, with no duplication or loss.
- Reset mid-DECRYPT (init low at output 20) -> all outputs at reset values within the same cycle; a following req runs cleanly.
- Sweep all 9 patterns with preamble 26 and random seeds -> correct ptrn_idx every run.
